cam_pix_capture: RTL and testbench

CAM_PIX_CAPTURE -- requirements
Module: cam_pix_capture

---
 rtl/cam_pix_capture_pkg.sv | 20 ++
 rtl/cam_pix_capture_pix_pack.sv | 48 ++++
 rtl/cam_pix_capture.sv | 187 ++++++++++++++++++
 tb/tb_cam_pix_capture.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pix_capture_pkg.sv
// Shared encodings for the camera pixel capture block.
package cam_pix_capture_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PACK_W = 16;

  typedef enum logic [1:0] {
    MODE_RGB444 = 2'd0,
    MODE_RGB565 = 2'd1,
    MODE_YUV_Y  = 2'd2,
    MODE_RAW8   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/cam_pix_capture_pix_pack.sv
// Assembles camera bytes into pixel words according to the frame's pixel format.
module pix_pack
  import cam_pix_capture_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_phase,
  input  mode_e             i_mode,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_done_c,
  output logic [PACK_W-1:0] o_pix_c
);

  logic [BYTE_W-1:0] b0_q;
  logic [BYTE_W-1:0] b0_d;

  // Hold the first byte of a pair; the second byte completes the pixel.
  always_comb begin
    b0_d     = b0_q;
    o_done_c = 1'b0;
    o_pix_c  = '0;
    if (i_mode == MODE_RAW8) begin
      o_done_c = i_valid;
      o_pix_c  = PACK_W'(i_byte);
    end else begin
      if (i_valid && !i_phase) begin
        b0_d = i_byte;
      end
      o_done_c = i_valid && i_phase;
      case (i_mode)
        MODE_RGB444: o_pix_c = {4'b0000, b0_q[3:0], i_byte};
        MODE_RGB565: o_pix_c = {b0_q, i_byte};
        default:     o_pix_c = PACK_W'(b0_q);
      endcase
    end
  end

  // First-byte holding register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b0_q <= '0;
    end else begin
      b0_q <= b0_d;
    end
  end

endmodule

// File: rtl/cam_pix_capture.sv
// Camera pixel capture: frame sync FSM, line/column tracking and frame-buffer addressing.
module cam_pix_capture
  import cam_pix_capture_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned PIX_W  = 16
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_cam_done,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_D,
  input  logic [1:0]        i_mode,
  input  logic              i_decim,
  output logic              o_wren,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_cnt,
  output logic              o_line_err
);

  localparam int unsigned XW    = 16;
  localparam int unsigned CNT_W = 16;
  localparam logic [ADDR_W:0] FULL_LIM = (ADDR_W+1)'(IMG_W * IMG_H);
  localparam logic [ADDR_W:0] DEC_LIM  = (ADDR_W+1)'((IMG_W / 2) * (IMG_H / 2));
  localparam logic [XW-1:0]   X_LINE   = XW'(IMG_W);
  localparam logic [XW-1:0]   X_MAX    = '1;

  state_e              state_q, state_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  mode_e               mode_q, mode_d;
  logic                decim_q, decim_d;
  logic                phase_q, phase_d;
  logic [XW-1:0]       x_q, x_d;
  logic                y_q, y_d;            // only line parity is needed
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic [PIX_W-1:0]    pix_data_q, pix_data_d;
  logic                frame_done_q, frame_done_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                line_err_q, line_err_d;

  logic                vsync_fall_c, vsync_rise_c, href_rise_c, href_fall_c;
  logic                pack_valid_c, phase_eff_c, pix_done_c, write_ok_c;
  logic [PACK_W-1:0]   pix_c;
  logic [ADDR_W:0]     lim_c;

  assign vsync_fall_c = vsync_q & ~i_vsync;
  assign vsync_rise_c = ~vsync_q & i_vsync;
  assign href_rise_c  = ~href_q & i_href;
  assign href_fall_c  = href_q & ~i_href;
  assign phase_eff_c  = href_rise_c ? 1'b0 : phase_q;
  assign pack_valid_c = (state_q == ST_ACTIVE) && i_cam_done && !vsync_rise_c && i_href;
  assign lim_c        = decim_q ? DEC_LIM : FULL_LIM;
  assign write_ok_c   = (!decim_q || (!x_q[0] && !y_q)) && ({1'b0, addr_q} < lim_c);

  pix_pack u_pix_pack (
    .i_clk   (i_pclk),
    .i_rst   (i_rst),
    .i_valid (pack_valid_c),
    .i_phase (phase_eff_c),
    .i_mode  (mode_q),
    .i_byte  (i_D),
    .o_done_c(pix_done_c),
    .o_pix_c (pix_c)
  );

  // Next-state: frame sync, byte phase, counters and write port.
  always_comb begin
    state_d      = state_q;
    vsync_d      = i_vsync;
    href_d       = i_href;
    mode_d       = mode_q;
    decim_d      = decim_q;
    phase_d      = phase_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    err_d        = err_q;
    wren_d       = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cam_done) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!i_cam_done) begin
          state_d = ST_IDLE;
        end else if (vsync_fall_c) begin
          state_d = ST_ACTIVE;
          mode_d  = mode_e'(i_mode);
          decim_d = i_decim;
          addr_d  = '0;
          x_d     = '0;
          y_d     = 1'b0;
          err_d   = 1'b0;
          phase_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!i_cam_done) begin
          state_d = ST_IDLE;
        end else if (vsync_rise_c) begin
          state_d      = ST_SYNC;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          line_err_d   = err_q;
        end else if (i_href) begin
          phase_d = (mode_q == MODE_RAW8) ? 1'b0 : ~phase_eff_c;
          if (pix_done_c) begin
            if (x_q != X_MAX) x_d = x_q + XW'(1);
            if (write_ok_c) begin
              wren_d     = 1'b1;
              pix_addr_d = addr_q;
              pix_data_d = PIX_W'(pix_c);
              addr_d     = addr_q + ADDR_W'(1);
            end
          end
        end else if (href_fall_c) begin
          y_d     = ~y_q;
          if (x_q != X_LINE) err_d = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      mode_q       <= MODE_RGB444;
      decim_q      <= 1'b0;
      phase_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= 1'b0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      wren_q       <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      mode_q       <= mode_d;
      decim_q      <= decim_d;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      wren_q       <= wren_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
    end
  end

  assign o_wren       = wren_q;
  assign o_pix_addr   = pix_addr_q;
  assign o_pix_data   = pix_data_q;
  assign o_frame_done = frame_done_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_line_err   = line_err_q;

endmodule

// File: tb/tb_cam_pix_capture.sv
// Bench for cam_pix_capture: two instances (4x2 and 4x4) sharing one camera stream.
module tb_cam_pix_capture;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HD = 4;
  localparam int AW = 19;
  localparam int PW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  typedef struct {
    int         mode;
    bit         decim;
    int         nlines;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         exp_wr;
    int         exp_last;
    logic [15:0] exp_first;
    bit         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst, cam_done, vsync, href, decim;
  logic [7:0] d;
  logic [1:0] mode;

  logic          wren_a, fdone_a, lerr_a, wren_b, fdone_b, lerr_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [PW-1:0] data_a, data_b;
  logic [15:0]   fcnt_a, fcnt_b;

  cam_pix_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
    .i_pclk(clk), .i_rst(rst), .i_cam_done(cam_done), .i_vsync(vsync), .i_href(href),
    .i_D(d), .i_mode(mode), .i_decim(decim),
    .o_wren(wren_a), .o_pix_addr(addr_a), .o_pix_data(data_a),
    .o_frame_done(fdone_a), .o_frame_cnt(fcnt_a), .o_line_err(lerr_a)
  );

  cam_pix_capture #(.IMG_W(W), .IMG_H(HD), .ADDR_W(AW), .PIX_W(PW)) dut_d (
    .i_pclk(clk), .i_rst(rst), .i_cam_done(cam_done), .i_vsync(vsync), .i_href(href),
    .i_D(d), .i_mode(mode), .i_decim(decim),
    .o_wren(wren_b), .o_pix_addr(addr_b), .o_pix_data(data_b),
    .o_frame_done(fdone_b), .o_frame_cnt(fcnt_b), .o_line_err(lerr_b)
  );

  always #5 clk = ~clk;

  wr_t got_a[$];
  wr_t got_b[$];
  int  fd_a = 0;
  int  fd_b = 0;

  // Capture memory writes and frame-done pulses away from the active edge.
  always @(negedge clk) begin
    if (wren_a) got_a.push_back({addr_a, data_a});
    if (wren_b) got_b.push_back({addr_b, data_b});
    if (fdone_a) fd_a++;
    if (fdone_b) fd_b++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;
  int mode_l;
  bit decim_l;

  logic [7:0] ln_bytes [4][16];
  int         ln_len [4];
  int         n_lines;

  wr_t exp_q[$];
  bit  exp_err;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected writes of a whole frame from the line contents and frame settings.
  task automatic model(input int md, input bit dc, input int h);
    int lim, cnt, npix;
    logic [7:0]  b0, b1;
    logic [15:0] px;
    exp_q.delete();
    exp_err = 1'b0;
    cnt = 0;
    lim = dc ? (W / 2) * (h / 2) : W * h;
    for (int l = 0; l < n_lines; l++) begin
      npix = (md == 3) ? ln_len[l] : ln_len[l] / 2;
      if (npix != W) exp_err = 1'b1;
      for (int x = 0; x < npix; x++) begin
        if (md == 3) begin
          px = {8'h00, ln_bytes[l][x]};
        end else begin
          b0 = ln_bytes[l][2*x];
          b1 = ln_bytes[l][2*x+1];
          case (md)
            0:       px = {4'h0, b0[3:0], b1};
            1:       px = {b0, b1};
            default: px = {8'h00, b0};
          endcase
        end
        if ((!dc || (x % 2 == 0 && l % 2 == 0)) && cnt < lim) begin
          exp_q.push_back({AW'(cnt), px});
          cnt++;
        end
      end
    end
  endtask

  task automatic run_frame(input int md, input bit dc, input bit chg);
    mode  = 2'(md);
    decim = dc;
    href  = 1'b0;
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    repeat (3) step();
    for (int l = 0; l < n_lines; l++) begin
      href = 1'b1;
      for (int i = 0; i < ln_len[l]; i++) begin
        d = ln_bytes[l][i];
        if (chg) begin
          mode  = 2'($urandom);
          decim = 1'($urandom);
        end
        step();
      end
      href = 1'b0;
      d    = 8'h00;
      repeat (2) step();
    end
    vsync = 1'b1;
    repeat (3) step();
  endtask

  task automatic check_dut(input string nm, input bit is_b, input int base, input int fd0,
                           input int h, input int exp_cnt);
    int  n;
    wr_t w;
    string tag;
    tag = is_b ? {nm, "/b"} : {nm, "/a"};
    model(mode_l, decim_l, h);
    n = (is_b ? got_b.size() : got_a.size()) - base;
    check({tag, " writes"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      w = is_b ? got_b[base+i] : got_a[base+i];
      check($sformatf("%s wr%0d", tag, i), 64'(w), 64'(exp_q[i]));
    end
    check({tag, " frame_done"}, 64'((is_b ? fd_b : fd_a) - fd0), 64'd1);
    check({tag, " frame_cnt"}, 64'(is_b ? fcnt_b : fcnt_a), 64'(16'(exp_cnt)));
    check({tag, " line_err"}, 64'(is_b ? lerr_b : lerr_a), 64'(exp_err));
  endtask

  task automatic frame_and_check(input string nm, input int md, input bit dc, input bit chg,
                                 output int base_a);
    int bb, fa, fb;
    base_a = got_a.size();
    bb = got_b.size();
    fa = fd_a;
    fb = fd_b;
    mode_l  = md;
    decim_l = dc;
    run_frame(md, dc, chg);
    cnt_a++;
    cnt_b++;
    check_dut(nm, 1'b0, base_a, fa, H, cnt_a);
    check_dut(nm, 1'b1, bb, fb, HD, cnt_b);
  endtask

  task automatic fill_clean(input int nl);
    n_lines = nl;
    for (int l = 0; l < nl; l++) begin
      ln_len[l] = 2 * W;
      for (int i = 0; i < 2 * W; i++) ln_bytes[l][i] = 8'($urandom);
    end
  endtask

  // Start a line, disturb it with reset or a config drop, and confirm nothing is written.
  task automatic abort_mid_line(input string nm, input bit use_rst);
    int ba, bb, fa, fb, dummy;
    fill_clean(1);
    mode  = 2'd1;
    decim = 1'b0;
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    repeat (3) step();
    href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = ln_bytes[0][i];
      step();
    end
    if (use_rst) rst = 1'b1; else cam_done = 1'b0;
    d = 8'h5A;
    repeat (2) step();
    ba = got_a.size();
    bb = got_b.size();
    fa = fd_a;
    fb = fd_b;
    rst = 1'b0;
    cam_done = 1'b1;
    if (use_rst) begin
      cnt_a = 0;
      cnt_b = 0;
    end
    for (int i = 0; i < 6; i++) begin
      d = 8'(i * 8'h13);
      step();
    end
    href = 1'b0;
    repeat (2) step();
    vsync = 1'b1;
    repeat (3) step();
    check({nm, " no writes a"}, 64'(got_a.size() - ba), 64'd0);
    check({nm, " no writes b"}, 64'(got_b.size() - bb), 64'd0);
    check({nm, " no frame_done"}, 64'(fd_a - fa + fd_b - fb), 64'd0);
    check({nm, " frame_cnt held"}, 64'(fcnt_a), 64'(16'(cnt_a)));
    fill_clean(2);
    frame_and_check({nm, " restart"}, 1, 1'b0, 1'b0, dummy);
    check({nm, " restart addr0"}, 64'((got_a.size() > ba) ? got_a[ba].addr : AW'(5)), 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    int ba, n, npix;
    logic [63:0] lastv, firstv;

    tbl[0] = '{0, 1'b0, 2,  8, 8'h0A, 8'hBC, 8, 7, 16'h0ABC, 1'b0};
    tbl[1] = '{3, 1'b0, 1,  4, 8'h11, 8'h22, 4, 3, 16'h0011, 1'b0};
    tbl[2] = '{1, 1'b0, 1,  6, 8'h12, 8'h34, 3, 2, 16'h1234, 1'b1};
    tbl[3] = '{1, 1'b0, 2,  8, 8'h56, 8'h78, 8, 7, 16'h5678, 1'b0};
    tbl[4] = '{1, 1'b0, 3,  8, 8'hAB, 8'hCD, 8, 7, 16'hABCD, 1'b0};
    tbl[5] = '{2, 1'b0, 1,  8, 8'h9F, 8'h01, 4, 3, 16'h009F, 1'b0};
    tbl[6] = '{0, 1'b0, 1,  9, 8'hF5, 8'h66, 4, 3, 16'h0566, 1'b0};
    tbl[7] = '{1, 1'b1, 4,  8, 8'h12, 8'h34, 2, 1, 16'h1234, 1'b0};

    rst = 1'b1; cam_done = 1'b1; vsync = 1'b0; href = 1'b0;
    d = 8'h00; mode = 2'd0; decim = 1'b0;
    repeat (3) step();
    check("reset wren",       64'(wren_a),  64'd0);
    check("reset addr",       64'(addr_a),  64'd0);
    check("reset data",       64'(data_a),  64'd0);
    check("reset frame_done", 64'(fdone_a), 64'd0);
    check("reset frame_cnt",  64'(fcnt_a),  64'd0);
    check("reset line_err",   64'(lerr_a),  64'd0);
    rst = 1'b0;
    repeat (2) step();

    for (int r = 0; r < 8; r++) begin
      n_lines = tbl[r].nlines;
      for (int l = 0; l < n_lines; l++) begin
        ln_len[l] = tbl[r].nbytes;
        for (int i = 0; i < tbl[r].nbytes; i++) begin
          if (l == 0 && i == 0)      ln_bytes[l][i] = tbl[r].b0;
          else if (l == 0 && i == 1) ln_bytes[l][i] = tbl[r].b1;
          else                       ln_bytes[l][i] = 8'(8'h11 * (i + 1) + l);
        end
      end
      frame_and_check($sformatf("vec%0d", r), tbl[r].mode, tbl[r].decim, 1'b0, ba);
      n = got_a.size() - ba;
      lastv  = (n > 0) ? 64'(got_a[got_a.size()-1].addr) : 64'hDEAD;
      firstv = (n > 0) ? 64'(got_a[ba].data) : 64'hDEAD;
      check($sformatf("vec%0d count", r), 64'(n), 64'(tbl[r].exp_wr));
      check($sformatf("vec%0d last addr", r), lastv, 64'(tbl[r].exp_last));
      check($sformatf("vec%0d first data", r), firstv, 64'(tbl[r].exp_first));
      check($sformatf("vec%0d line_err", r), 64'(lerr_a), 64'(tbl[r].exp_err));
    end

    abort_mid_line("rst", 1'b1);
    abort_mid_line("camdrop", 1'b0);

    for (int r = 0; r < 24; r++) begin
      mode_l  = int'($urandom_range(0, 3));
      decim_l = 1'($urandom);
      n_lines = int'($urandom_range(1, 4));
      for (int l = 0; l < n_lines; l++) begin
        npix = W - 1 + int'($urandom_range(0, 2));
        ln_len[l] = (mode_l == 3) ? npix : 2 * npix + int'($urandom_range(0, 1));
        for (int i = 0; i < ln_len[l]; i++) ln_bytes[l][i] = 8'($urandom);
      end
      frame_and_check($sformatf("rnd%0d", r), mode_l, decim_l, 1'b1, ba);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
